// File: rtl/tpu_pkg.sv
// tpu_pkg: shared TPU host-bus widths, result row geometry and unloader state encoding.
package tpu_pkg;
  localparam int BYTE_WIDTH   = 8;
  localparam int NUM_RESULTS  = 4;
  localparam int RESULT_WIDTH = 16;
  localparam int ROW_WIDTH    = NUM_RESULTS * RESULT_WIDTH;
  localparam int TOTAL_BYTES  = ROW_WIDTH / BYTE_WIDTH;
  localparam int IDX_W        = $clog2(TOTAL_BYTES);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
endpackage

// File: rtl/result_unloader_if.sv
// result_unloader_if: array-side capture and host-side byte stream signals of the result unloader.
interface result_unloader_if;
  import tpu_pkg::*;
  logic                    result_valid;
  logic [RESULT_WIDTH-1:0] result_1;
  logic [RESULT_WIDTH-1:0] result_2;
  logic [RESULT_WIDTH-1:0] result_3;
  logic [RESULT_WIDTH-1:0] result_4;
  logic                    result_ready;
  logic [BYTE_WIDTH-1:0]   out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  modport slave (
    input  result_valid, result_1, result_2, result_3, result_4, out_ready,
    output result_ready, out_data, out_valid, out_last
  );
  modport master (
    output result_valid, result_1, result_2, result_3, result_4, out_ready,
    input  result_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/result_unloader.sv
// result_unloader: captures one row of accumulator results and streams it to the host
// one byte per valid/ready transfer, little-endian per result, results in column order.
module result_unloader
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  result_unloader_if.slave bus,
  output logic             busy,
  output logic             overrun
);
  logic [0:0]                                state_q, state_d;
  logic [IDX_W-1:0]                          idx_q, idx_d;
  logic [TOTAL_BYTES-1:0][BYTE_WIDTH-1:0]    row_q, row_d;
  logic                                      overrun_q, overrun_d;
  logic                                      send, capture, xfer;
  assign send    = state_q == SEND;
  assign capture = !send && bus.result_valid;
  assign xfer    = send && bus.out_ready;
  // Ready is held low while reset is asserted so every output reads 0 during reset.
  assign bus.result_ready = !send && !rst;
  assign bus.out_valid    = send;
  assign bus.out_last     = send && idx_q == IDX_W'(TOTAL_BYTES - 1);
  assign bus.out_data     = row_q[idx_q];
  assign busy             = send;
  assign overrun          = overrun_q;
  always_comb begin
    state_d   = capture ? SEND : (xfer && bus.out_last) ? IDLE : state_q;
    idx_d     = capture ? '0 : (xfer && !bus.out_last) ? idx_q + 1'b1 : idx_q;
    row_d     = capture ? {bus.result_4, bus.result_3, bus.result_2, bus.result_1} : row_q;
    overrun_d = overrun_q || (bus.result_valid && send);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      row_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      overrun_q <= overrun_d;
    end
  end
endmodule

// File: tb/tb_result_unloader.sv
// tb_result_unloader: directed table-driven and hand-sequenced checks of result_unloader.
module tb_result_unloader;
  import tpu_pkg::*;
  typedef struct {
    logic       rv;
    logic       ordy;
    logic       ev;
    logic       el;
    logic [7:0] ed;
  } vec_t;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic busy, overrun;
  int n_vec = 0;
  int n_fail = 0;
  vec_t tbl [25];
  logic [7:0] exp_a [8] = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h88, 8'h77};
  logic [7:0] exp_b [8] = '{8'hB2, 8'hA1, 8'hD4, 8'hC3, 8'hF6, 8'hE5, 8'h18, 8'h07};
  logic [7:0] exp_c [8] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h80};

  result_unloader_if bus ();

  result_unloader dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 if (clk_en) clk = ~clk;

  function automatic vec_t mk(logic rv, logic ordy, logic ev, logic [7:0] ed, logic el);
    vec_t v;
    v.rv = rv; v.ordy = ordy; v.ev = ev; v.ed = ed; v.el = el;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_row(input logic [15:0] r1, r2, r3, r4);
    bus.result_1 = r1; bus.result_2 = r2; bus.result_3 = r3; bus.result_4 = r4;
  endtask

  task automatic capture(input logic [15:0] r1, r2, r3, r4);
    @(negedge clk);
    chk("capture_ready", 16'(bus.result_ready), 16'h1);
    set_row(r1, r2, r3, r4);
    bus.result_valid = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  task automatic stream(input logic [7:0] e [8], input int from);
    for (int k = from; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("stream_valid%0d", k), 16'(bus.out_valid), 16'h1);
      chk($sformatf("stream_data%0d", k), 16'(bus.out_data), 16'(e[k]));
      chk($sformatf("stream_last%0d", k), 16'(bus.out_last), (k == 7) ? 16'h1 : 16'h0);
      bus.result_valid = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("stream_end_ready", 16'(bus.result_ready), 16'h1);
    chk("stream_end_valid", 16'(bus.out_valid), 16'h0);
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 0, 8'h00, 0);
    tbl[1]  = mk(0, 1, 1, 8'h22, 0);
    tbl[2]  = mk(0, 1, 1, 8'h11, 0);
    tbl[3]  = mk(0, 1, 1, 8'h44, 0);
    tbl[4]  = mk(0, 1, 1, 8'h33, 0);
    tbl[5]  = mk(0, 1, 1, 8'h66, 0);
    tbl[6]  = mk(0, 1, 1, 8'h55, 0);
    tbl[7]  = mk(0, 1, 1, 8'h88, 0);
    tbl[8]  = mk(0, 1, 1, 8'h77, 1);
    tbl[9]  = mk(1, 0, 0, 8'h00, 0);
    tbl[10] = mk(0, 1, 1, 8'h22, 0);
    tbl[11] = mk(0, 0, 1, 8'h11, 0);
    tbl[12] = mk(0, 0, 1, 8'h11, 0);
    tbl[13] = mk(0, 1, 1, 8'h11, 0);
    tbl[14] = mk(0, 0, 1, 8'h44, 0);
    tbl[15] = mk(0, 0, 1, 8'h44, 0);
    tbl[16] = mk(0, 1, 1, 8'h44, 0);
    tbl[17] = mk(0, 1, 1, 8'h33, 0);
    tbl[18] = mk(0, 0, 1, 8'h66, 0);
    tbl[19] = mk(0, 1, 1, 8'h66, 0);
    tbl[20] = mk(0, 1, 1, 8'h55, 0);
    tbl[21] = mk(0, 1, 1, 8'h88, 0);
    tbl[22] = mk(0, 0, 1, 8'h77, 1);
    tbl[23] = mk(0, 1, 1, 8'h77, 1);
    tbl[24] = mk(0, 0, 0, 8'h00, 0);

    bus.result_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_row(16'h0, 16'h0, 16'h0, 16'h0);

    // Reset with the clock stopped: outputs must clear asynchronously.
    #2 rst = 1'b1;
    #1;
    chk("rst_out_data", 16'(bus.out_data), 16'h0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'h0);
    chk("rst_out_last", 16'(bus.out_last), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);
    chk("rst_ready", 16'(bus.result_ready), 16'h0);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_ready", 16'(bus.result_ready), 16'h1);
    chk("post_rst_valid", 16'(bus.out_valid), 16'h0);
    clk_en = 1'b1;

    // Full-rate stream then backpressured stream of the same row.
    set_row(16'h1122, 16'h3344, 16'h5566, 16'h7788);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 16'(bus.out_valid), 16'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 16'(bus.result_ready), 16'(!tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i), 16'(busy), 16'(tbl[i].ev));
      chk($sformatf("tbl%0d_last", i), 16'(bus.out_last), 16'(tbl[i].el));
      chk($sformatf("tbl%0d_overrun", i), 16'(overrun), 16'h0);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), 16'(bus.out_data), 16'(tbl[i].ed));
      bus.result_valid = tbl[i].rv;
      bus.out_ready = tbl[i].ordy;
    end

    // Overrun: a row offered mid-stream is dropped and flagged.
    capture(16'h1122, 16'h3344, 16'h5566, 16'h7788);
    @(negedge clk);
    chk("ovr_first", 16'(bus.out_data), 16'h0022);
    chk("ovr_before", 16'(overrun), 16'h0);
    bus.result_valid = 1'b1;
    bus.result_1 = 16'hFFFF;
    stream(exp_a, 1);
    chk("ovr_set", 16'(overrun), 16'h1);
    capture(16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718);
    stream(exp_b, 0);
    chk("ovr_sticky", 16'(overrun), 16'h1);

    // Reset mid-row aborts the stream and clears overrun.
    capture(16'h1122, 16'h3344, 16'h5566, 16'h7788);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort_data%0d", k), 16'(bus.out_data), 16'(exp_a[k]));
      bus.result_valid = 1'b0;
    end
    @(negedge clk);
    chk("abort_pre_data", 16'(bus.out_data), 16'h0033);
    #1 rst = 1'b1;
    #1;
    chk("abort_valid", 16'(bus.out_valid), 16'h0);
    chk("abort_busy", 16'(busy), 16'h0);
    chk("abort_data", 16'(bus.out_data), 16'h0);
    chk("abort_overrun", 16'(overrun), 16'h0);
    #1 rst = 1'b0;
    #1;
    chk("abort_ready", 16'(bus.result_ready), 16'h1);
    capture(16'h0001, 16'h0002, 16'h0003, 16'h8000);
    stream(exp_c, 0);

    // Back-to-back: result_valid held high, rows captured every 9 cycles.
    bus.out_ready = 1'b1;
    set_row(16'h1122, 16'h3344, 16'h5566, 16'h7788);
    @(negedge clk);
    chk("b2b_idle", 16'(bus.result_ready), 16'h1);
    bus.result_valid = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      if ((k - 1) % 9 < 8) begin
        chk($sformatf("b2b%0d_valid", k), 16'(bus.out_valid), 16'h1);
        chk($sformatf("b2b%0d_data", k), 16'(bus.out_data), 16'(exp_a[(k - 1) % 9]));
      end else begin
        chk($sformatf("b2b%0d_ready", k), 16'(bus.result_ready), 16'h1);
        chk($sformatf("b2b%0d_idle", k), 16'(bus.out_valid), 16'h0);
      end
      chk($sformatf("b2b%0d_overrun", k), 16'(overrun), (k >= 2) ? 16'h1 : 16'h0);
    end
    bus.result_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/result_unloader.md
Name: result_unloader

Overview:
Readback path of the TPU: the counterpart to the weight loader that moves bytes from the Raspberry Pi into the array. It captures one row of four accumulator results from the systolic array in a single cycle, then streams them to the RPi one byte at a time over a valid/ready handshake. It sits between the array outputs and the 8-bit host bus, mirroring the byte-wide host interface used for weight loading.

Parameters:
NUM_RESULTS, 4, accumulator results captured per row
RESULT_WIDTH, 16, bits per accumulator result (multiple of 8)
BYTE_WIDTH, 8, host bus width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
result_valid  input  1  array presents a valid result row this cycle
result_1  input  16  accumulator result, column 1
result_2  input  16  accumulator result, column 2
result_3  input  16  accumulator result, column 3
result_4  input  16  accumulator result, column 4
result_ready  output  1  unloader can accept a row (high only in IDLE)
out_data  output  8  byte to RPi
out_valid  output  1  out_data is valid
out_ready  input  1  RPi accepts the byte this cycle
out_last  output  1  current byte is the final byte of the row
busy  output  1  row held, streaming in progress
overrun  output  1  sticky: a row was offered while result_ready was low

Behaviour:
- Reset (async, rst high): state=IDLE, byte_idx=0, shadow regs=0, out_data=0, out_valid=0, out_last=0, busy=0, overrun=0. result_ready=1 once rst deasserts.
- TOTAL_BYTES = NUM_RESULTS*RESULT_WIDTH/BYTE_WIDTH = 8. byte_idx is 3 bits and never wraps past 7.
- States: IDLE, SEND.
- IDLE: result_ready=1, out_valid=0, busy=0. If result_valid, on the next edge latch all four results into the shadow regs, set byte_idx=0, and go to SEND.
- SEND: result_ready=0, busy=1, out_valid=1. out_data = byte byte_idx of the shadow row. out_last=1 iff byte_idx==TOTAL_BYTES-1.
- Byte order is little-endian per result, results in column order: idx0=result_1[7:0], idx1=result_1[15:8], idx2=result_2[7:0], and so on to idx7=result_4[15:8]. Data is sent raw, two's complement, with no saturation.
- Handshake: a transfer occurs when out_valid && out_ready. On a transfer with out_last=0, byte_idx increments. On a transfer with out_last=1, the next state is IDLE and out_valid drops the next cycle.
- Stall: if out_ready is low, out_data, out_valid and out_last hold stable. out_valid must never drop without a transfer.
- Latency: the first byte is valid 1 cycle after capture. With out_ready held high, all 8 bytes go out in 8 consecutive cycles. result_ready returns high the cycle after the last transfer, so the minimum row period is 9 cycles.
- Shadow regs are loaded only on capture. Changes on result_* during SEND have no effect.
- overrun: set on any cycle with result_valid=1 && result_ready=0. Cleared only by rst. That row is dropped and the row being streamed is unaffected.
- result_valid and a last-byte transfer in the same cycle: result_ready is still 0, so the row is not accepted and overrun is set. The producer must wait for result_ready.
- rst asserted mid-SEND aborts the row immediately. No partial resume.

Decomposition:
- Shared package tpu_pkg holds the state encoding (IDLE=0, SEND=1), BYTE_WIDTH, and the TOTAL_BYTES derivation. The weight loader uses the same package for host bus width.
- Single module, no sub-module. The byte select is an indexed mux over the shadow row.

Test Plan:
1. Reset then idle: rst pulse with clk stopped -> all outputs 0 asynchronously; after release, result_ready=1 and out_valid=0.
2. Full-rate stream: result_1..4 = 16'h1122, 16'h3344, 16'h5566, 16'h7788, result_valid for 1 cycle, out_ready=1 -> bytes 22,11,44,33,66,55,88,77 on 8 consecutive cycles; out_last only on 77; result_ready=1 on the following cycle.
3. Backpressure: same row with out_ready toggling 1,0,0,1,… -> out_data holds during 0 cycles, byte sequence unchanged, no byte duplicated or skipped.
4. Overrun: during SEND, pulse result_valid with result_1=16'hFFFF -> overrun=1 and stays 1; the streamed row is still the original values; the next accepted row streams correctly.
5. Reset mid-row: assert rst after 3 transfers -> out_valid=0 immediately; after release, a new row 16'h0001,16'h0002,16'h0003,16'h8000 streams 01,00,02,00,03,00,00,80.
6. Back-to-back: result_valid held high continuously with out_ready=1 -> rows captured every 9 cycles; overrun=1 from the second cycle on (expected, sticky).
